race_timer: RTL and testbench

Elapsed-time counter for the text overlay. It runs a stopwatch at 10 µs resolution from the 50 MHz clock and presents hours, minutes, seconds and a 5-digit sub-second field. It also supports start/stop/clear control and a lap freeze. Its outputs feed the on-screen timer character writer directly, so every output is a register or a mux of registers.

---
 rtl/race_timer.sv | 130 +++++++++++++
 tb/tb_race_timer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/race_timer.sv
// Stopwatch for the on-screen timer overlay: counts h:m:s plus a sub-second field
// at TICK_DIV clock cycles per unit, with start/stop/clear control and a lap freeze.
//
// state     | meaning
// IDLE      | cleared, not counting
// RUNNING   | prescaler and live counters advancing
// STOPPED   | paused, prescaler phase kept for resume
// SATURATED | live value pinned at HOURS_MAX:59:59.SUB_MAX
module race_timer #(
  parameter int TICK_DIV  = 500,
  parameter int SUB_MAX   = 99999,
  parameter int HOURS_MAX = 59
) (
  input  logic        clock50MHz,
  input  logic        resetn,
  input  logic        startPulse,
  input  logic        stopPulse,
  input  logic        clearPulse,
  input  logic        lapPulse,
  output logic [5:0]  hours,
  output logic [5:0]  minutes,
  output logic [5:0]  seconds,
  output logic [16:0] subSeconds,
  output logic        running,
  output logic        lapHeld,
  output logic        maxReached,
  output logic        secondTick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [16:0]   SUB_LAST   = 17'(SUB_MAX);
  localparam logic [5:0]    HOURS_LAST = 6'(HOURS_MAX);

  typedef enum logic [1:0] {IDLE, RUNNING, STOPPED, SATURATED} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [5:0]    liveH, liveM, liveS;
  logic [16:0]   liveSub;
  logic [5:0]    lapH, lapM, lapS;
  logic [16:0]   lapSub;

  logic stopAct, startAct, lapAct, counting, advance, atMax;

  // Only the highest-priority request that applies in the current state acts.
  always_comb begin
    stopAct  = stopPulse && (state == RUNNING);
    startAct = !stopAct && startPulse && ((state == IDLE) || (state == STOPPED));
    lapAct   = !stopAct && !startAct && lapPulse && (lapHeld || (state == RUNNING));
    counting = (state == RUNNING) && !stopAct;
    advance  = counting && (presc == PRESC_LAST);
    atMax    = (liveH == HOURS_LAST) && (liveM == 6'd59) && (liveS == 6'd59) &&
               (liveSub == SUB_LAST);
  end

  always_ff @(posedge clock50MHz) begin
    if (!resetn || clearPulse) begin
      state      <= IDLE;
      presc      <= '0;
      liveH      <= '0;
      liveM      <= '0;
      liveS      <= '0;
      liveSub    <= '0;
      lapH       <= '0;
      lapM       <= '0;
      lapS       <= '0;
      lapSub     <= '0;
      running    <= 1'b0;
      lapHeld    <= 1'b0;
      maxReached <= 1'b0;
      secondTick <= 1'b0;
    end else begin
      secondTick <= 1'b0;

      if (stopAct) begin
        state   <= STOPPED;
        running <= 1'b0;
      end else if (startAct) begin
        state   <= RUNNING;
        running <= 1'b1;
      end else if (lapAct) begin
        if (lapHeld) begin
          lapHeld <= 1'b0;
        end else begin
          lapHeld <= 1'b1;
          lapH    <= liveH;
          lapM    <= liveM;
          lapS    <= liveS;
          lapSub  <= liveSub;
        end
      end

      if (counting) begin
        if (advance && atMax) begin
          state      <= SATURATED;
          running    <= 1'b0;
          maxReached <= 1'b1;
        end else begin
          presc <= advance ? '0 : presc + 1'b1;
          if (advance) begin
            if (liveSub != SUB_LAST) begin
              liveSub <= liveSub + 1'b1;
            end else begin
              liveSub    <= '0;
              secondTick <= 1'b1;
              if (liveS != 6'd59) begin
                liveS <= liveS + 1'b1;
              end else begin
                liveS <= '0;
                if (liveM != 6'd59) begin
                  liveM <= liveM + 1'b1;
                end else begin
                  liveM <= '0;
                  liveH <= liveH + 1'b1;
                end
              end
            end
          end
        end
      end
    end
  end

  assign hours      = lapHeld ? lapH   : liveH;
  assign minutes    = lapHeld ? lapM   : liveM;
  assign seconds    = lapHeld ? lapS   : liveS;
  assign subSeconds = lapHeld ? lapSub : liveSub;

endmodule

// File: tb/tb_race_timer.sv
// Directed bench for race_timer: three instances with small parameters so the
// cascade, saturation and prescaler-phase cases fit in a short run.
module tb_race_timer;

  logic clock50MHz = 1'b0;
  logic resetn = 1'b0;
  logic startP [3];
  logic stopP [3];
  logic clearP [3];
  logic lapP [3];
  logic [5:0]  hours [3];
  logic [5:0]  minutes [3];
  logic [5:0]  seconds [3];
  logic [16:0] subSeconds [3];
  logic        running [3];
  logic        lapHeld [3];
  logic        maxReached [3];
  logic        secondTick [3];
  logic [42:0] obs [3];

  int passed = 0;
  int total  = 0;

  always #10 clock50MHz = ~clock50MHz;

  // A: fast, HOURS_MAX=1 (start, lap, cascade); B: fast, HOURS_MAX=0 (saturation);
  // C: TICK_DIV=500 at full sub-second range (prescaler phase).
  race_timer #(.TICK_DIV(2), .SUB_MAX(1), .HOURS_MAX(1)) dutA (
    .clock50MHz(clock50MHz), .resetn(resetn),
    .startPulse(startP[0]), .stopPulse(stopP[0]), .clearPulse(clearP[0]), .lapPulse(lapP[0]),
    .hours(hours[0]), .minutes(minutes[0]), .seconds(seconds[0]), .subSeconds(subSeconds[0]),
    .running(running[0]), .lapHeld(lapHeld[0]), .maxReached(maxReached[0]),
    .secondTick(secondTick[0]));

  race_timer #(.TICK_DIV(2), .SUB_MAX(1), .HOURS_MAX(0)) dutB (
    .clock50MHz(clock50MHz), .resetn(resetn),
    .startPulse(startP[1]), .stopPulse(stopP[1]), .clearPulse(clearP[1]), .lapPulse(lapP[1]),
    .hours(hours[1]), .minutes(minutes[1]), .seconds(seconds[1]), .subSeconds(subSeconds[1]),
    .running(running[1]), .lapHeld(lapHeld[1]), .maxReached(maxReached[1]),
    .secondTick(secondTick[1]));

  race_timer #(.TICK_DIV(500), .SUB_MAX(99999), .HOURS_MAX(59)) dutC (
    .clock50MHz(clock50MHz), .resetn(resetn),
    .startPulse(startP[2]), .stopPulse(stopP[2]), .clearPulse(clearP[2]), .lapPulse(lapP[2]),
    .hours(hours[2]), .minutes(minutes[2]), .seconds(seconds[2]), .subSeconds(subSeconds[2]),
    .running(running[2]), .lapHeld(lapHeld[2]), .maxReached(maxReached[2]),
    .secondTick(secondTick[2]));

  always_comb begin
    for (int i = 0; i < 3; i++)
      obs[i] = {hours[i], minutes[i], seconds[i], subSeconds[i],
                running[i], lapHeld[i], maxReached[i], secondTick[i]};
  end

  function automatic logic [42:0] st(input int h, input int m, input int s, input int sub,
                                     input bit r, input bit l, input bit mx, input bit t);
    st = {6'(h), 6'(m), 6'(s), 17'(sub), r, l, mx, t};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clock50MHz);
  endtask

  // Drives a request for exactly one sampling edge; returns at the following negedge.
  task automatic pulse(input int i, input bit c, input bit p, input bit s, input bit l);
    clearP[i] = c; stopP[i] = p; startP[i] = s; lapP[i] = l;
    @(negedge clock50MHz);
    clearP[i] = 1'b0; stopP[i] = 1'b0; startP[i] = 1'b0; lapP[i] = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    tick(3);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs[i] !== st(0, 0, 0, 0, 0, 0, 0, 0))
        $display("FAIL reset_held dut%0d got %h want %h", i, obs[i], st(0, 0, 0, 0, 0, 0, 0, 0));
      else passed++;
    end
    resetn = 1'b1;
    tick(2);
    total++;
    if (obs[0] !== st(0, 0, 0, 0, 0, 0, 0, 0))
      $display("FAIL reset_released got %h want %h", obs[0], st(0, 0, 0, 0, 0, 0, 0, 0));
    else passed++;
  endtask

  task automatic test_start;
    pulse(0, 0, 0, 1, 0);
    total++;
    if (obs[0] !== st(0, 0, 0, 0, 1, 0, 0, 0))
      $display("FAIL start_running got %h want %h", obs[0], st(0, 0, 0, 0, 1, 0, 0, 0));
    else passed++;
    tick(3);
    total++;
    if (obs[0] !== st(0, 0, 0, 1, 1, 0, 0, 0))
      $display("FAIL start_sub1 got %h want %h", obs[0], st(0, 0, 0, 1, 1, 0, 0, 0));
    else passed++;
    tick(1);
    total++;
    if (obs[0] !== st(0, 0, 1, 0, 1, 0, 0, 1))
      $display("FAIL start_second got %h want %h", obs[0], st(0, 0, 1, 0, 1, 0, 0, 1));
    else passed++;
    tick(1);
    total++;
    if (obs[0] !== st(0, 0, 1, 0, 1, 0, 0, 0))
      $display("FAIL start_tick_once got %h want %h", obs[0], st(0, 0, 1, 0, 1, 0, 0, 0));
    else passed++;
  endtask

  // Lap sampled on an advance edge (live 3.1 -> 4.0) must capture 3.1.
  task automatic test_lap;
    pulse(0, 1, 0, 0, 0);
    pulse(0, 0, 0, 1, 0);
    tick(15);
    pulse(0, 0, 0, 0, 1);
    total++;
    if (obs[0] !== st(0, 0, 3, 1, 1, 1, 0, 1))
      $display("FAIL lap_capture got %h want %h", obs[0], st(0, 0, 3, 1, 1, 1, 0, 1));
    else passed++;
    tick(10);
    total++;
    if (obs[0] !== st(0, 0, 3, 1, 1, 1, 0, 0))
      $display("FAIL lap_frozen got %h want %h", obs[0], st(0, 0, 3, 1, 1, 1, 0, 0));
    else passed++;
    pulse(0, 0, 0, 0, 1);
    total++;
    if (obs[0] !== st(0, 0, 6, 1, 1, 0, 0, 0))
      $display("FAIL lap_release got %h want %h", obs[0], st(0, 0, 6, 1, 1, 0, 0, 0));
    else passed++;
  endtask

  task automatic test_stop_lap;
    pulse(0, 0, 1, 0, 1);
    total++;
    if (obs[0] !== st(0, 0, 6, 1, 0, 0, 0, 0))
      $display("FAIL stop_lap got %h want %h", obs[0], st(0, 0, 6, 1, 0, 0, 0, 0));
    else passed++;
    tick(10);
    total++;
    if (obs[0] !== st(0, 0, 6, 1, 0, 0, 0, 0))
      $display("FAIL stopped_hold got %h want %h", obs[0], st(0, 0, 6, 1, 0, 0, 0, 0));
    else passed++;
  endtask

  task automatic test_clear_start;
    pulse(0, 1, 0, 1, 0);
    total++;
    if (obs[0] !== st(0, 0, 0, 0, 0, 0, 0, 0))
      $display("FAIL clear_start got %h want %h", obs[0], st(0, 0, 0, 0, 0, 0, 0, 0));
    else passed++;
    tick(5);
    total++;
    if (obs[0] !== st(0, 0, 0, 0, 0, 0, 0, 0))
      $display("FAIL clear_idle got %h want %h", obs[0], st(0, 0, 0, 0, 0, 0, 0, 0));
    else passed++;
  endtask

  task automatic test_cascade;
    pulse(0, 0, 0, 1, 0);
    tick(14399);
    total++;
    if (obs[0] !== st(0, 59, 59, 1, 1, 0, 0, 0))
      $display("FAIL cascade_pre got %h want %h", obs[0], st(0, 59, 59, 1, 1, 0, 0, 0));
    else passed++;
    tick(1);
    total++;
    if (obs[0] !== st(1, 0, 0, 0, 1, 0, 0, 1))
      $display("FAIL cascade_wrap got %h want %h", obs[0], st(1, 0, 0, 0, 1, 0, 0, 1));
    else passed++;
  endtask

  task automatic test_saturation;
    pulse(1, 0, 0, 1, 0);
    tick(14399);
    total++;
    if (obs[1] !== st(0, 59, 59, 1, 1, 0, 0, 0))
      $display("FAIL sat_pre got %h want %h", obs[1], st(0, 59, 59, 1, 1, 0, 0, 0));
    else passed++;
    tick(1);
    total++;
    if (obs[1] !== st(0, 59, 59, 1, 0, 0, 1, 0))
      $display("FAIL sat_enter got %h want %h", obs[1], st(0, 59, 59, 1, 0, 0, 1, 0));
    else passed++;
    tick(10);
    pulse(1, 0, 0, 1, 0);
    pulse(1, 0, 1, 0, 0);
    total++;
    if (obs[1] !== st(0, 59, 59, 1, 0, 0, 1, 0))
      $display("FAIL sat_hold got %h want %h", obs[1], st(0, 59, 59, 1, 0, 0, 1, 0));
    else passed++;
    pulse(1, 1, 0, 0, 0);
    total++;
    if (obs[1] !== st(0, 0, 0, 0, 0, 0, 0, 0))
      $display("FAIL sat_clear got %h want %h", obs[1], st(0, 0, 0, 0, 0, 0, 0, 0));
    else passed++;
  endtask

  task automatic test_first_advance;
    pulse(2, 0, 0, 1, 0);
    tick(499);
    total++;
    if (obs[2] !== st(0, 0, 0, 0, 1, 0, 0, 0))
      $display("FAIL first_adv_early got %h want %h", obs[2], st(0, 0, 0, 0, 1, 0, 0, 0));
    else passed++;
    tick(1);
    total++;
    if (obs[2] !== st(0, 0, 0, 1, 1, 0, 0, 0))
      $display("FAIL first_adv got %h want %h", obs[2], st(0, 0, 0, 1, 1, 0, 0, 0));
    else passed++;
    pulse(2, 1, 0, 0, 0);
  endtask

  // Stop sampled while presc==300; resume must advance exactly 200 edges later.
  task automatic test_pause;
    pulse(2, 0, 0, 1, 0);
    tick(300);
    pulse(2, 0, 1, 0, 0);
    tick(1000);
    total++;
    if (obs[2] !== st(0, 0, 0, 0, 0, 0, 0, 0))
      $display("FAIL pause_hold got %h want %h", obs[2], st(0, 0, 0, 0, 0, 0, 0, 0));
    else passed++;
    pulse(2, 0, 0, 1, 0);
    tick(199);
    total++;
    if (obs[2] !== st(0, 0, 0, 0, 1, 0, 0, 0))
      $display("FAIL resume_early got %h want %h", obs[2], st(0, 0, 0, 0, 1, 0, 0, 0));
    else passed++;
    tick(1);
    total++;
    if (obs[2] !== st(0, 0, 0, 1, 1, 0, 0, 0))
      $display("FAIL resume_adv got %h want %h", obs[2], st(0, 0, 0, 1, 1, 0, 0, 0));
    else passed++;
  endtask

  task automatic test_reset_midrun;
    startP[0] = 1'b1;
    resetn = 1'b0;
    @(negedge clock50MHz);
    startP[0] = 1'b0;
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs[i] !== st(0, 0, 0, 0, 0, 0, 0, 0))
        $display("FAIL reset_midrun dut%0d got %h want %h", i, obs[i], st(0, 0, 0, 0, 0, 0, 0, 0));
      else passed++;
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      startP[i] = 1'b0; stopP[i] = 1'b0; clearP[i] = 1'b0; lapP[i] = 1'b0;
    end
    @(negedge clock50MHz);
    test_reset;
    test_start;
    test_lap;
    test_stop_lap;
    test_clear_start;
    test_cascade;
    test_saturation;
    test_first_advance;
    test_pause;
    test_reset_midrun;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
